// File: rtl/mem_chk_pkg.sv
// mem_chk_pkg: shared types and helpers for the memory range checker.
// The optional stop-on-first-error behaviour is selected in the top-level
// file with the MEM_CHK_STOP_ON_ERR_EN macro; nothing here depends on it.
package mem_chk_pkg;

    // Checker sequencing states, 3-bit encoding.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WR    = 3'd1,
        ST_RD    = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Values of mode_i.
    localparam logic MODE_RD_ONLY = 1'b0;
    localparam logic MODE_WR_RD   = 1'b1;

    // Fill/check pattern: seed plus the offset from the first location.
    // Computed at 32 bits; callers truncate to the memory data width.
    function automatic logic [31:0] expected(input logic [31:0] seed,
                                             input logic [31:0] offset);
        return seed + offset;
    endfunction

endpackage

// File: rtl/mem_chk_addr_gen.sv
// mem_chk_addr_gen: loadable address counter used for both the write and
// the read sweep. Tracks the current address, its offset from the first
// location of the sweep, and how many locations remain. The address never
// advances past the final location, so a full-range sweep ends at DEPTH-1.
module mem_chk_addr_gen #(
    parameter int ADDR_LINES = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  load_i,
    input  logic [ADDR_LINES-1:0] load_addr_i,
    input  logic [ADDR_LINES:0]   load_cnt_i,
    input  logic                  adv_i,
    output logic [ADDR_LINES-1:0] addr_o,
    output logic [ADDR_LINES:0]   offset_o,
    output logic                  last_o
);

    logic [ADDR_LINES-1:0] addr_q;
    logic [ADDR_LINES:0]   off_q;
    logic [ADDR_LINES:0]   rem_q;

    // Load a new sweep, or step to the next location on an accepted request.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q <= '0;
            off_q  <= '0;
            rem_q  <= '0;
        end else if (load_i) begin
            addr_q <= load_addr_i;
            off_q  <= '0;
            rem_q  <= load_cnt_i;
        end else if (adv_i && (rem_q != '0)) begin
            rem_q <= rem_q - 1'b1;
            if (!last_o) begin
                addr_q <= addr_q + 1'b1;
                off_q  <= off_q + 1'b1;
            end
        end
    end

    assign addr_o   = addr_q;
    assign offset_o = off_q;
    assign last_o   = (rem_q == {{ADDR_LINES{1'b0}}, 1'b1});

endmodule

// File: rtl/mem_range_checker.sv
// mem_range_checker: initiator on a valid/ready memory port that optionally
// fills an address range with a seed-based pattern and then reads it back,
// counting mismatches and recording the first failing address.
// Optional feature macro: MEM_CHK_STOP_ON_ERR_EN -- when defined, the first
// mismatch ends the read sweep (no further reads are issued).
module mem_range_checker
    import mem_chk_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 1024,
    parameter int ADDR_LINES = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic                  mode_i,
    input  logic [ADDR_LINES:0]   start_addr_i,
    input  logic [ADDR_LINES:0]   num_locs_i,
    input  logic [WIDTH-1:0]      seed_i,
    output logic                  valid_o,
    output logic                  wr_rd_o,
    output logic [ADDR_LINES-1:0] addr_o,
    output logic [WIDTH-1:0]      wr_data_o,
    input  logic                  ready_i,
    input  logic [WIDTH-1:0]      rd_data_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  range_err_o,
    output logic [ADDR_LINES:0]   err_cnt_o,
    output logic [ADDR_LINES-1:0] first_err_addr_o
);

    state_e                state_q, state_d;
    logic                  mode_q, mode_d;
    logic [ADDR_LINES:0]   start_q, start_d;
    logic [ADDR_LINES:0]   num_q, num_d;
    logic [WIDTH-1:0]      seed_q, seed_d;
    logic                  range_err_q, range_err_d;
    logic [ADDR_LINES:0]   err_cnt_q, err_cnt_d;
    logic [ADDR_LINES-1:0] first_err_q, first_err_d;

    // One outstanding read awaiting its data on the following cycle.
    logic                  pend_q, pend_d;
    logic [ADDR_LINES-1:0] pend_addr_q, pend_addr_d;
    logic [WIDTH-1:0]      pend_exp_q, pend_exp_d;

    logic                  gen_load, gen_adv, gen_last;
    logic [ADDR_LINES-1:0] gen_load_addr, gen_addr;
    logic [ADDR_LINES:0]   gen_load_cnt, gen_off;

    logic [ADDR_LINES+1:0] end_sum;
    logic                  out_of_range;
    logic [WIDTH-1:0]      exp_data;
    logic                  mismatch;
    logic                  stop_now;

    mem_chk_addr_gen #(
        .ADDR_LINES (ADDR_LINES)
    ) u_addr_gen (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .load_i      (gen_load),
        .load_addr_i (gen_load_addr),
        .load_cnt_i  (gen_load_cnt),
        .adv_i       (gen_adv),
        .addr_o      (gen_addr),
        .offset_o    (gen_off),
        .last_o      (gen_last)
    );

    // Range end is formed one bit wider than the operands so it cannot wrap.
    assign end_sum      = {1'b0, start_addr_i} + {1'b0, num_locs_i};
    assign out_of_range = (end_sum > (ADDR_LINES+2)'(DEPTH));

    // Pattern value for the location the address generator points at.
    assign exp_data = WIDTH'(expected(32'(seed_q), 32'(gen_off)));

    // Read data belongs to the read accepted on the previous cycle.
    assign mismatch = pend_q && (rd_data_i != pend_exp_q);

`ifdef MEM_CHK_STOP_ON_ERR_EN
    assign stop_now = mismatch;
`else
    assign stop_now = 1'b0;
`endif

    // Next-state, datapath updates and port outputs.
    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        start_d       = start_q;
        num_d         = num_q;
        seed_d        = seed_q;
        range_err_d   = range_err_q;
        err_cnt_d     = err_cnt_q;
        first_err_d   = first_err_q;
        pend_d        = pend_q;
        pend_addr_d   = pend_addr_q;
        pend_exp_d    = pend_exp_q;
        gen_load      = 1'b0;
        gen_adv       = 1'b0;
        gen_load_addr = start_q[ADDR_LINES-1:0];
        gen_load_cnt  = num_q;
        valid_o       = 1'b0;
        wr_rd_o       = 1'b0;
        wr_data_o     = '0;
        busy_o        = 1'b0;
        done_o        = 1'b0;

        // Retire the outstanding read; a new acceptance below may re-arm it.
        if (pend_q && ((state_q == ST_RD) || (state_q == ST_DRAIN))) begin
            pend_d = 1'b0;
            if (mismatch) begin
                if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
                if (err_cnt_q == '0) first_err_d = pend_addr_q;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    mode_d      = mode_i;
                    start_d     = start_addr_i;
                    num_d       = num_locs_i;
                    seed_d      = seed_i;
                    err_cnt_d   = '0;
                    first_err_d = '0;
                    range_err_d = 1'b0;
                    pend_d      = 1'b0;
                    if (out_of_range) begin
                        range_err_d = 1'b1;
                        state_d     = ST_DONE;
                    end else if (num_locs_i == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        gen_load      = 1'b1;
                        gen_load_addr = start_addr_i[ADDR_LINES-1:0];
                        gen_load_cnt  = num_locs_i;
                        state_d       = (mode_i == MODE_WR_RD) ? ST_WR : ST_RD;
                    end
                end
            end
            ST_WR: begin
                busy_o    = 1'b1;
                valid_o   = 1'b1;
                wr_rd_o   = 1'b1;
                wr_data_o = exp_data;
                if (ready_i) begin
                    gen_adv = 1'b1;
                    if (gen_last) begin
                        // Reload for the read sweep; the load wins over adv.
                        gen_load = 1'b1;
                        state_d  = ST_RD;
                    end
                end
            end
            ST_RD: begin
                busy_o = 1'b1;
                if (stop_now) begin
                    state_d = ST_DRAIN;
                end else begin
                    valid_o = 1'b1;
                    if (ready_i) begin
                        gen_adv     = 1'b1;
                        pend_d      = 1'b1;
                        pend_addr_d = gen_addr;
                        pend_exp_d  = exp_data;
                        if (gen_last) state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                busy_o  = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Register all state; reset returns the checker to an idle, clean slate.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_RD_ONLY;
            start_q     <= '0;
            num_q       <= '0;
            seed_q      <= '0;
            range_err_q <= 1'b0;
            err_cnt_q   <= '0;
            first_err_q <= '0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            pend_exp_q  <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            start_q     <= start_d;
            num_q       <= num_d;
            seed_q      <= seed_d;
            range_err_q <= range_err_d;
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            pend_exp_q  <= pend_exp_d;
        end
    end

    assign addr_o           = valid_o ? gen_addr : '0;
    assign range_err_o      = range_err_q;
    assign err_cnt_o        = err_cnt_q;
    assign first_err_addr_o = first_err_q;

endmodule

// File: tb/tb_mem_range_checker.sv
// Self-checking bench for mem_range_checker: a behavioural memory with
// configurable ready behaviour, a transfer log, and a reference model that
// predicts counts, first error address and the expected transfer sequence.
module tb_mem_range_checker;

    localparam int WIDTH = 8;
    localparam int DEPTH = 1024;
    localparam int AL    = 10;
    localparam int MASK  = (1 << WIDTH) - 1;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic            start_i = 1'b0;
    logic            mode_i = 1'b0;
    logic [AL:0]     start_addr_i = '0;
    logic [AL:0]     num_locs_i = '0;
    logic [WIDTH-1:0] seed_i = '0;
    logic            valid_o, wr_rd_o;
    logic [AL-1:0]   addr_o;
    logic [WIDTH-1:0] wr_data_o;
    logic            ready_i = 1'b1;
    logic [WIDTH-1:0] rd_data_i = '0;
    logic            busy_o, done_o, range_err_o;
    logic [AL:0]     err_cnt_o;
    logic [AL-1:0]   first_err_addr_o;

    int total = 0;
    int bad   = 0;

    mem_range_checker #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_LINES(AL)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .mode_i(mode_i),
        .start_addr_i(start_addr_i), .num_locs_i(num_locs_i), .seed_i(seed_i),
        .valid_o(valid_o), .wr_rd_o(wr_rd_o), .addr_o(addr_o), .wr_data_o(wr_data_o),
        .ready_i(ready_i), .rd_data_i(rd_data_i), .busy_o(busy_o), .done_o(done_o),
        .range_err_o(range_err_o), .err_cnt_o(err_cnt_o),
        .first_err_addr_o(first_err_addr_o)
    );

    always #5 clk_i = ~clk_i;

    // Memory contents, transfer log and stall-stability tracking.
    logic [WIDTH-1:0] mem [DEPTH];
    int  log_a[$];
    bit  log_w[$];
    int  log_d[$];
    int  rdy_mode  = 0;
    int  stall_bad = 0;
    logic held_v = 1'b0;
    logic [AL+WIDTH:0] held_f = '0;

    always @(negedge clk_i) begin
        case (rdy_mode)
            0:       ready_i = 1'b1;
            1:       ready_i = ~ready_i;
            default: ready_i = 1'($urandom_range(0, 1));
        endcase
    end

    always @(posedge clk_i) begin
        if (held_v && valid_o && ({wr_rd_o, addr_o, wr_data_o} != held_f)) stall_bad++;
        held_v = valid_o && !ready_i;
        held_f = {wr_rd_o, addr_o, wr_data_o};
        if (valid_o && ready_i) begin
            log_a.push_back(int'(addr_o));
            log_w.push_back(wr_rd_o);
            log_d.push_back(int'(wr_data_o));
        end
        if (valid_o && ready_i && wr_rd_o) mem[addr_o] = wr_data_o;
        if (valid_o && ready_i && !wr_rd_o) rd_data_i <= mem[addr_o];
        else                                rd_data_i <= WIDTH'($urandom);
    end

    // Reference model: derived from pattern rule and current memory image.
    int m_err, m_first, m_range, m_nlog, m_lastrd;
    function automatic void model(bit m, int s, int n, int sd);
        int e;
        int act;
        m_err = 0; m_first = 0; m_range = ((s + n) > DEPTH) ? 1 : 0;
        m_nlog = 0; m_lastrd = -1;
        if (m_range != 0 || n == 0) return;
        m_nlog = m ? n : 0;
        for (int i = 0; i < n; i++) begin
            e   = (sd + i) & MASK;
            act = m ? e : int'(mem[s + i]);
            m_nlog++;
            m_lastrd = s + i;
            if (act != e) begin
                if (m_err == 0) m_first = s + i;
                m_err++;
`ifdef MEM_CHK_STOP_ON_ERR_EN
                break;
`endif
            end
        end
    endfunction

    // Number of logged transfers that deviate from the expected sequence.
    function automatic int log_errors(bit m, int s, int n, int sd);
        int errs = 0;
        int j;
        for (int k = 0; k < log_a.size(); k++) begin
            if (m && k < n) begin
                if (!log_w[k] || log_a[k] != s + k || log_d[k] != ((sd + k) & MASK)) errs++;
            end else begin
                j = m ? k - n : k;
                if (log_w[k] || log_a[k] != s + j) errs++;
            end
        end
        return errs;
    endfunction

    int r_busy, r_done;
    bit r_to;
    task automatic do_run(input bit m, input int s, input int n, input int sd);
        log_a.delete(); log_w.delete(); log_d.delete();
        @(negedge clk_i);
        start_i = 1'b1; mode_i = m; start_addr_i = (AL+1)'(s);
        num_locs_i = (AL+1)'(n); seed_i = WIDTH'(sd);
        @(negedge clk_i);
        start_i = 1'b0;
        r_busy = 0; r_done = 0; r_to = 1'b1;
        for (int c = 0; c < 6000; c++) begin
            if (busy_o) r_busy++;
            if (done_o) begin
                r_done++; r_to = 1'b0;
                @(negedge clk_i);
                if (done_o) r_done++;
                break;
            end
            @(negedge clk_i);
        end
    endtask

    task automatic test_reset;
        #1;
        total++;
        if ({valid_o, busy_o, done_o, range_err_o} !== 4'b0) begin
            bad++; $display("FAIL reset_flags: got %b want 0000", {valid_o, busy_o, done_o, range_err_o});
        end
        total++;
        if (err_cnt_o !== '0 || first_err_addr_o !== '0) begin
            bad++; $display("FAIL reset_err: got cnt=%0d first=%0d want 0 0", err_cnt_o, first_err_addr_o);
        end
        total++;
        if (addr_o !== '0 || wr_data_o !== '0) begin
            bad++; $display("FAIL reset_req: got addr=%0d data=%0d want 0 0", addr_o, wr_data_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic test_wr_rd_basic;
        rdy_mode = 0;
        model(1'b1, 16, 8, 'hA0);
        do_run(1'b1, 16, 8, 'hA0);
        total++;
        if (r_to || r_done != 1) begin bad++; $display("FAIL basic_done: got pulses=%0d want 1", r_done); end
        total++;
        if (r_busy != 17) begin bad++; $display("FAIL basic_busy: got %0d want 17", r_busy); end
        total++;
        if (int'(err_cnt_o) != m_err) begin bad++; $display("FAIL basic_err: got %0d want %0d", err_cnt_o, m_err); end
        total++;
        if (log_a.size() != m_nlog) begin bad++; $display("FAIL basic_nlog: got %0d want %0d", log_a.size(), m_nlog); end
        total++;
        if (log_errors(1'b1, 16, 8, 'hA0) != 0) begin
            bad++; $display("FAIL basic_seq: got %0d bad transfers want 0", log_errors(1'b1, 16, 8, 'hA0));
        end
        total++;
        if (log_d.size() < 8 || log_d[7] != 'hA7) begin bad++; $display("FAIL basic_wdata7: want a7"); end
    endtask

    task automatic test_preload_mismatch;
        for (int i = 0; i < 32; i++) mem[i] = WIDTH'(i);
        mem[5] = 8'hFF;
        model(1'b0, 0, 32, 0);
        do_run(1'b0, 0, 32, 0);
        total++;
        if (int'(err_cnt_o) != m_err) begin bad++; $display("FAIL pre_err: got %0d want %0d", err_cnt_o, m_err); end
        total++;
        if (int'(first_err_addr_o) != m_first) begin
            bad++; $display("FAIL pre_first: got %0d want %0d", first_err_addr_o, m_first);
        end
        total++;
        if (log_a.size() != m_nlog || log_errors(1'b0, 0, 32, 0) != 0) begin
            bad++; $display("FAIL pre_seq: got %0d reads want %0d", log_a.size(), m_nlog);
        end
    endtask

    task automatic test_two_errors;
        for (int i = 0; i < 16; i++) mem[i] = WIDTH'(i);
        mem[3] = 8'h55; mem[9] = 8'h55;
        model(1'b0, 0, 16, 0);
        do_run(1'b0, 0, 16, 0);
        total++;
        if (int'(err_cnt_o) != m_err || int'(first_err_addr_o) != m_first) begin
            bad++; $display("FAIL two_err: got cnt=%0d first=%0d want %0d %0d", err_cnt_o, first_err_addr_o, m_err, m_first);
        end
        total++;
        if (log_a.size() != m_nlog || log_a.size() == 0 || log_a[$] != m_lastrd) begin
            bad++; $display("FAIL two_reads: got n=%0d want n=%0d last=%0d", log_a.size(), m_nlog, m_lastrd);
        end
        total++;
        if (r_to || r_done != 1) begin bad++; $display("FAIL two_done: got pulses=%0d want 1", r_done); end
    endtask

    task automatic test_stall;
        rdy_mode = 1; stall_bad = 0;
        model(1'b1, 0, 4, 'h33);
        do_run(1'b1, 0, 4, 'h33);
        rdy_mode = 0;
        total++;
        if (stall_bad != 0) begin bad++; $display("FAIL stall_stable: got %0d changes want 0", stall_bad); end
        total++;
        if (log_a.size() != 8 || log_errors(1'b1, 0, 4, 'h33) != 0) begin
            bad++; $display("FAIL stall_seq: got %0d transfers want 8", log_a.size());
        end
        total++;
        if (err_cnt_o !== '0 || r_done != 1) begin
            bad++; $display("FAIL stall_err: got cnt=%0d done=%0d want 0 1", err_cnt_o, r_done);
        end
    endtask

    task automatic test_range;
        do_run(1'b0, 1020, 8, 0);
        total++;
        if (range_err_o !== 1'b1 || log_a.size() != 0 || r_done != 1) begin
            bad++; $display("FAIL range_over: got rerr=%b n=%0d done=%0d want 1 0 1", range_err_o, log_a.size(), r_done);
        end
        do_run(1'b0, 0, 0, 0);
        total++;
        if (range_err_o !== 1'b0 || log_a.size() != 0 || r_done != 1 || r_busy != 0) begin
            bad++; $display("FAIL range_zero: got rerr=%b n=%0d done=%0d want 0 0 1", range_err_o, log_a.size(), r_done);
        end
    endtask

    task automatic test_full_range;
        model(1'b1, 0, DEPTH, 'h5A);
        do_run(1'b1, 0, DEPTH, 'h5A);
        total++;
        if (log_a.size() != 2 * DEPTH || log_a[DEPTH-1] != DEPTH - 1 || log_a[$] != DEPTH - 1) begin
            bad++; $display("FAIL full_last: got n=%0d want %0d ending at %0d", log_a.size(), 2 * DEPTH, DEPTH - 1);
        end
        total++;
        if (err_cnt_o !== '0 || range_err_o !== 1'b0 || log_errors(1'b1, 0, DEPTH, 'h5A) != 0) begin
            bad++; $display("FAIL full_err: got cnt=%0d rerr=%b want 0 0", err_cnt_o, range_err_o);
        end
    endtask

    task automatic test_start_while_busy;
        rdy_mode = 2;
        model(1'b1, 100, 10, 7);
        log_a.delete(); log_w.delete(); log_d.delete();
        @(negedge clk_i);
        start_i = 1'b1; mode_i = 1'b1; start_addr_i = 100; num_locs_i = 10; seed_i = 7;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (4) @(negedge clk_i);
        start_i = 1'b1; mode_i = 1'b0; start_addr_i = 200; num_locs_i = 3; seed_i = 99;
        @(negedge clk_i);
        start_i = 1'b0;
        r_to = 1'b1;
        for (int c = 0; c < 500; c++) begin
            if (done_o) begin r_to = 1'b0; break; end
            @(negedge clk_i);
        end
        rdy_mode = 0;
        total++;
        if (r_to || log_a.size() != m_nlog || log_errors(1'b1, 100, 10, 7) != 0) begin
            bad++; $display("FAIL busy_start: got n=%0d timeout=%0d want %0d 0", log_a.size(), r_to, m_nlog);
        end
        @(negedge clk_i);
    endtask

    task automatic test_random;
        bit m; int s, n, sd, e;
        rdy_mode = 2;
        for (int it = 0; it < 8; it++) begin
            m  = 1'($urandom_range(0, 1));
            n  = (it == 3) ? 200 : int'($urandom_range(0, 60));
            s  = (it == 3) ? int'($urandom_range(900, 1000)) : int'($urandom_range(0, DEPTH - 64));
            sd = int'($urandom_range(0, MASK));
            for (int i = 0; i < n && s + i < DEPTH; i++) begin
                e = (sd + i) & MASK;
                mem[s + i] = ($urandom_range(0, 7) == 0) ? WIDTH'(e ^ 1) : WIDTH'(e);
            end
            model(m, s, n, sd);
            stall_bad = 0;
            do_run(m, s, n, sd);
            total++;
            if (r_to || int'(err_cnt_o) != m_err || int'(first_err_addr_o) != m_first
                || int'(range_err_o) != m_range) begin
                bad++; $display("FAIL rand_%0d: got cnt=%0d first=%0d rerr=%b want %0d %0d %0d",
                                it, err_cnt_o, first_err_addr_o, range_err_o, m_err, m_first, m_range);
            end
            total++;
            if (log_a.size() != m_nlog || log_errors(m, s, n, sd) != 0 || stall_bad != 0) begin
                bad++; $display("FAIL rand_seq_%0d: got n=%0d want %0d stallchg=%0d", it, log_a.size(), m_nlog, stall_bad);
            end
        end
        rdy_mode = 0;
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 32; i++) mem[i] = WIDTH'(i);
        mem[1] = 8'hEE; mem[2] = 8'hEE;
        @(negedge clk_i);
        start_i = 1'b1; mode_i = 1'b0; start_addr_i = 0; num_locs_i = 32; seed_i = 0;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (8) @(negedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        total++;
        if (valid_o !== 1'b0 || busy_o !== 1'b0 || err_cnt_o !== '0) begin
            bad++; $display("FAIL rst_mid: got valid=%b busy=%b cnt=%0d want 0 0 0", valid_o, busy_o, err_cnt_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int i = 0; i < 32; i++) mem[i] = WIDTH'(i);
        model(1'b0, 0, 32, 0);
        do_run(1'b0, 0, 32, 0);
        total++;
        if (r_to || err_cnt_o !== '0 || log_a.size() != m_nlog) begin
            bad++; $display("FAIL rst_rerun: got cnt=%0d n=%0d want 0 %0d", err_cnt_o, log_a.size(), m_nlog);
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        test_reset();
        test_wr_rd_basic();
        test_preload_mismatch();
        test_two_errors();
        test_stall();
        test_range();
        test_full_range();
        test_start_while_busy();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_range_checker.md
Name: mem_range_checker

Overview:
- Synthesizable initiator that drives the valid/ready memory port of the memory block, reading a contiguous address range back and checking the data.
- Can first fill the range with a deterministic pattern (write-then-read) or only verify the range (read-only), e.g. after a backdoor load.
- Reports mismatch count and first failing address.
- Sits between the control/CSR logic and the memory, replacing testbench-driven front-door traffic in silicon bring-up.

Parameters:
- WIDTH, 8, memory data width
- DEPTH, 1024, number of memory locations
- ADDR_LINES, 10, address width; DEPTH <= 2**ADDR_LINES

Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous active-low reset
- start_i  in  1  one-cycle pulse; ignored unless busy_o=0
- mode_i  in  1  0 = read-only check, 1 = write pattern then read-check
- start_addr_i  in  ADDR_LINES+1  first location, sampled at start
- num_locs_i  in  ADDR_LINES+1  location count, sampled at start
- seed_i  in  WIDTH  pattern seed, sampled at start
- valid_o  out  1  memory request valid
- wr_rd_o  out  1  1 = write, 0 = read
- addr_o  out  ADDR_LINES  request address
- wr_data_o  out  WIDTH  write data
- ready_i  in  1  memory accepts request this cycle
- rd_data_i  in  WIDTH  read data, valid one cycle after accepted read
- busy_o  out  1  operation in progress
- done_o  out  1  one-cycle completion pulse
- range_err_o  out  1  sticky until next start: start_addr+num_locs > DEPTH
- err_cnt_o  out  ADDR_LINES+1  mismatches in last run, saturating
- first_err_addr_o  out  ADDR_LINES  address of first mismatch; 0 if none

Behaviour:
- Reset: all outputs 0; FSM in IDLE.
- Transfer happens on a cycle with valid_o=1 and ready_i=1. Request fields stay stable while valid_o=1 and ready_i=0.
- Pattern: expected(a) = seed + (a - start_addr), mod 2**WIDTH.
- FSM states: IDLE, WR, RD, DRAIN, DONE.
- IDLE, on start_i:
  - Latch all inputs.
  - Clear err_cnt_o, first_err_addr_o and range_err_o.
  - If start+num > DEPTH (computed in ADDR_LINES+2 bits): set range_err_o, go to DONE, issue no requests.
  - Else if num=0: go to DONE.
  - Else go to WR if mode=1, otherwise RD.
- WR:
  - valid_o=1, wr_rd_o=1, addr_o = current address, wr_data_o = expected(addr).
  - Address advances on each transfer.
  - After the last transfer, go to RD at start_addr with no idle cycle.
- RD:
  - valid_o=1, wr_rd_o=0; reads issue back-to-back while ready_i=1.
  - Each accepted read sets a pending flag and saves its address/expected value.
  - Data is compared on the following cycle.
  - After the last accepted read, go to DRAIN.
- DRAIN:
  - valid_o=0; perform the final compare.
  - Go to DONE.
- DONE:
  - busy_o=0, done_o=1 for exactly one cycle, then IDLE.
  - Error outputs hold until the next start.
- busy_o=1 in WR, RD and DRAIN.
- Mismatch handling:
  - err_cnt_o increments and saturates at all-ones.
  - first_err_addr_o is written only on the first mismatch of a run.
- A compare and a new read acceptance in the same cycle are both handled; throughput is 1 location/cycle when ready_i stays high.
- Full range: start=0, num=DEPTH is legal; the address counter ends at DEPTH-1 without wrap.
- start_i while busy is ignored.
- Reset mid-run: immediate return to IDLE with outputs cleared. The memory sees valid_o drop asynchronously.

Optional Feature:
- Macro MEM_CHK_STOP_ON_ERR_EN.
- Defined: the first mismatch ends the run. No further reads issue; the FSM goes to DRAIN→DONE, and err_cnt_o = 1.
- Undefined: the full range is always checked and all mismatches are counted.

Decomposition:
- Package mem_chk_pkg:
  - FSM state enum (3-bit encoding).
  - Mode constants MODE_RD_ONLY and MODE_WR_RD.
  - Pattern function expected(seed, offset).
- Sub-module mem_chk_addr_gen: loadable address counter with remaining-count and last flag. It is reused for the WR and RD phases.

Test Plan:
- mode=1, start=16, num=8, seed=0xA0, ready_i always 1:
  - 8 writes with data 0xA0..0xA7, then 8 reads.
  - err_cnt_o=0 and done_o pulses; busy_o lasts 17 cycles.
- mode=0 on a memory preloaded with expected(seed=0x00) at 0..31, but location 5 forced to 0xFF:
  - err_cnt_o=1, first_err_addr_o=5.
- ready_i toggles 1/0 every cycle during mode=1, start=0, num=4:
  - Requests are held stable while stalled.
  - All 8 transfers complete with err_cnt_o=0.
- start=1020, num=8 (DEPTH=1024): no valid_o, range_err_o=1, done_o pulse. Then start=0, num=0: done_o with no requests and range_err_o cleared.
- start=0, num=1024, mode=1: the last address is 1023, no wrap, err_cnt_o=0.
- Reset asserted mid-RD: valid_o, busy_o and err_cnt_o are 0 immediately. A new start after release runs normally.
- With MEM_CHK_STOP_ON_ERR_EN and two corrupted locations 3 and 9: the run stops after addr 3, no read to 9, err_cnt_o=1.
